// File: rtl/mc_ctrl_fsm.sv
// Main control FSM of the multi-cycle RV32I core: sequences ALU, register file, IR and memory port.
// Optional macro MC_CTRL_ILLEGAL_TRAP_EN adds the illegal output and an absorbing TRAP state.
module mc_ctrl_fsm #(
   parameter logic [3:0] RESET_STATE = 4'd0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] op,
   input  logic       cond,
   input  logic       mem_rdy,
   output logic [1:0] alu_op,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] result_src,
   output logic       adr_src,
   output logic       ir_write,
   output logic       pc_write,
   output logic       reg_write,
   output logic       mem_write,
   output logic       instr_done,
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
   output logic       illegal,
`endif
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECR    = 4'd6,
      EXECI    = 4'd7,
      ALUWB    = 4'd8,
      BRANCH   = 4'd9,
      JAL      = 4'd10,
      JALR     = 4'd11,
      TRAP     = 4'd15
   } state_t;

   state_t st, nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) st <= state_t'(RESET_STATE);
      else        st <= nxt;
   end

   assign state = st;

   always_comb begin
      nxt        = st;
      alu_op     = 2'b00;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      result_src = 2'b00;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      instr_done = 1'b0;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      illegal    = 1'b0;
`endif
      case (st)
         FETCH: begin
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            ir_write   = mem_rdy;
            pc_write   = mem_rdy;
            if (mem_rdy) nxt = DECODE;
         end
         DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            case (op)
               7'b0000011, 7'b0100011: nxt = MEMADR;
               7'b0110011:             nxt = EXECR;
               7'b0010011:             nxt = EXECI;
               7'b1100011:             nxt = BRANCH;
               7'b1101111:             nxt = JAL;
               7'b1100111:             nxt = JALR;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
               default:                nxt = TRAP;
`else
               default:                nxt = FETCH;
`endif
            endcase
         end
         MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            nxt       = op[5] ? MEMWRITE : MEMREAD;
         end
         MEMREAD: begin
            adr_src = 1'b1;
            if (mem_rdy) nxt = MEMWB;
         end
         MEMWB: begin
            result_src = 2'b01;
            reg_write  = 1'b1;
            instr_done = 1'b1;
            nxt        = FETCH;
         end
         MEMWRITE: begin
            adr_src    = 1'b1;
            mem_write  = 1'b1;
            instr_done = mem_rdy;
            if (mem_rdy) nxt = FETCH;
         end
         EXECR: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b10;
            nxt       = ALUWB;
         end
         EXECI: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            alu_op    = 2'b10;
            nxt       = ALUWB;
         end
         ALUWB: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
            nxt        = FETCH;
         end
         BRANCH: begin
            alu_src_a  = 2'b10;
            alu_op     = 2'b01;
            pc_write   = cond;
            instr_done = 1'b1;
            nxt        = FETCH;
         end
         JALR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            nxt       = JAL;
         end
         JAL: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            pc_write  = 1'b1;
            nxt       = ALUWB;
         end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
         TRAP: begin
            illegal = 1'b1;
            nxt     = TRAP;
         end
`endif
         default: nxt = FETCH;
      endcase

      // Reset overrides the state decode so no strobe escapes while rst_n is low.
      if (!rst_n) begin
         alu_op     = 2'b00;
         alu_src_a  = 2'b00;
         alu_src_b  = 2'b10;
         result_src = 2'b10;
         adr_src    = 1'b0;
         ir_write   = 1'b0;
         pc_write   = 1'b0;
         reg_write  = 1'b0;
         mem_write  = 1'b0;
         instr_done = 1'b0;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
         illegal    = 1'b0;
`endif
      end
   end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed self-checking bench for mc_ctrl_fsm; honours MC_CTRL_ILLEGAL_TRAP_EN when defined.
module tb_mc_ctrl_fsm;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] op;
   logic       cond;
   logic       mem_rdy;
   logic [1:0] alu_op, alu_src_a, alu_src_b, result_src;
   logic       adr_src, ir_write, pc_write, reg_write, mem_write, instr_done;
   logic [3:0] state;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
   logic       illegal;
`endif

   int unsigned checks = 0;
   int unsigned errors = 0;

   // {ir_write, pc_write, reg_write, mem_write, instr_done}
   logic [4:0] strb;
   // {alu_op, alu_src_a, alu_src_b, result_src, adr_src}
   logic [8:0] sel;
   assign strb = {ir_write, pc_write, reg_write, mem_write, instr_done};
   assign sel  = {alu_op, alu_src_a, alu_src_b, result_src, adr_src};

   localparam logic [8:0] S_FETCH  = 9'b00_00_10_10_0;
   localparam logic [8:0] S_DECODE = 9'b00_01_01_00_0;
   localparam logic [8:0] S_MEMADR = 9'b00_10_01_00_0;
   localparam logic [8:0] S_MEMRW  = 9'b00_00_00_00_1;
   localparam logic [8:0] S_MEMWB  = 9'b00_00_00_01_0;
   localparam logic [8:0] S_EXECR  = 9'b10_10_00_00_0;
   localparam logic [8:0] S_EXECI  = 9'b10_10_01_00_0;
   localparam logic [8:0] S_ALUWB  = 9'b00_00_00_00_0;
   localparam logic [8:0] S_BRANCH = 9'b01_10_00_00_0;
   localparam logic [8:0] S_JAL    = 9'b00_01_10_00_0;
   localparam logic [8:0] S_JALR   = 9'b00_10_01_00_0;

   always #5 clk = ~clk;

   mc_ctrl_fsm #(.RESET_STATE(4'd0)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .op         (op),
      .cond       (cond),
      .mem_rdy    (mem_rdy),
      .alu_op     (alu_op),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .result_src (result_src),
      .adr_src    (adr_src),
      .ir_write   (ir_write),
      .pc_write   (pc_write),
      .reg_write  (reg_write),
      .mem_write  (mem_write),
      .instr_done (instr_done),
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      .illegal    (illegal),
`endif
      .state      (state)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic look(input string tag, input logic [3:0] st, input logic [4:0] s, input logic [8:0] c);
      chk({tag, ".state"}, {12'd0, state}, {12'd0, st});
      chk({tag, ".strb"},  {11'd0, strb},  {11'd0, s});
      chk({tag, ".sel"},   {7'd0, sel},    {7'd0, c});
   endtask

   initial begin
      rst_n = 1'b0; op = 7'd0; cond = 1'b0; mem_rdy = 1'b1;
      tick(); tick();
      look("reset", 4'd0, 5'b00000, S_FETCH);

      // release mid-cycle; single-cycle fetch
      rst_n = 1'b1; #1;
      look("fetch0", 4'd0, 5'b11000, S_FETCH);
      op = 7'b0110011;
      tick(); look("r.dec",   4'd1, 5'b00000, S_DECODE);
      tick(); look("r.execr", 4'd6, 5'b00000, S_EXECR);
      tick(); look("r.aluwb", 4'd8, 5'b00101, S_ALUWB);
      tick(); chk("r.back", {12'd0, state}, 16'd0);

      // fetch stall, then load with MEMREAD stall
      mem_rdy = 1'b0; #1;
      look("ld.fwait", 4'd0, 5'b00000, S_FETCH);
      tick(); look("ld.fwait2", 4'd0, 5'b00000, S_FETCH);
      mem_rdy = 1'b1; op = 7'b0000011; #1;
      chk("ld.fgo", {11'd0, strb}, 16'b11000);
      tick(); look("ld.dec", 4'd1, 5'b00000, S_DECODE);
      tick(); look("ld.adr", 4'd2, 5'b00000, S_MEMADR);
      tick(); mem_rdy = 1'b0; #1;
      look("ld.rd1", 4'd3, 5'b00000, S_MEMRW);
      tick(); look("ld.rd2", 4'd3, 5'b00000, S_MEMRW);
      tick(); look("ld.rd3", 4'd3, 5'b00000, S_MEMRW);
      mem_rdy = 1'b1;
      tick(); look("ld.wb", 4'd4, 5'b00101, S_MEMWB);
      tick(); chk("ld.back", {12'd0, state}, 16'd0);

      // store with one wait cycle
      op = 7'b0100011;
      tick(); tick();
      look("st.adr", 4'd2, 5'b00000, S_MEMADR);
      tick(); mem_rdy = 1'b0; #1;
      look("st.wait", 4'd5, 5'b00010, S_MEMRW);
      tick(); look("st.wait2", 4'd5, 5'b00010, S_MEMRW);
      mem_rdy = 1'b1; #1;
      chk("st.done", {11'd0, strb}, 16'b00011);
      tick(); chk("st.back", {12'd0, state}, 16'd0);

      // branch not taken, then taken
      op = 7'b1100011; cond = 1'b0;
      tick(); look("bn.dec", 4'd1, 5'b00000, S_DECODE);
      tick(); look("bn.br",  4'd9, 5'b00001, S_BRANCH);
      tick(); chk("bn.back", {12'd0, state}, 16'd0);
      cond = 1'b1;
      tick(); tick();
      look("bt.br", 4'd9, 5'b01001, S_BRANCH);
      tick(); chk("bt.back", {12'd0, state}, 16'd0);
      cond = 1'b0;

      // jalr: 1, 11, 10, 8
      op = 7'b1100111;
      tick(); look("jr.dec",  4'd1,  5'b00000, S_DECODE);
      tick(); look("jr.jalr", 4'd11, 5'b00000, S_JALR);
      tick(); look("jr.jal",  4'd10, 5'b01000, S_JAL);
      tick(); look("jr.wb",   4'd8,  5'b00101, S_ALUWB);
      tick(); chk("jr.back", {12'd0, state}, 16'd0);

      // jal, then I-type with mem_rdy low where it must be ignored
      op = 7'b1101111;
      tick(); tick();
      look("j.jal", 4'd10, 5'b01000, S_JAL);
      tick(); tick(); chk("j.back", {12'd0, state}, 16'd0);
      op = 7'b0010011;
      tick(); mem_rdy = 1'b0;
      tick(); look("i.execi", 4'd7, 5'b00000, S_EXECI);
      tick(); look("i.wb",    4'd8, 5'b00101, S_ALUWB);
      mem_rdy = 1'b1;
      tick(); chk("i.back", {12'd0, state}, 16'd0);

      // unknown opcode
      op = 7'b1111111;
      tick(); look("ill.dec", 4'd1, 5'b00000, S_DECODE);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      tick(); look("ill.trap", 4'd15, 5'b00000, 9'd0);
      chk("ill.flag", {15'd0, illegal}, 16'd1);
      tick(); tick();
      chk("ill.hold", {12'd0, state}, 16'd15);
      chk("ill.flag2", {15'd0, illegal}, 16'd1);
      rst_n = 1'b0; #1;
      chk("ill.rst", {12'd0, state}, 16'd0);
      chk("ill.clr", {15'd0, illegal}, 16'd0);
      tick(); rst_n = 1'b1; #1;
`else
      tick(); look("ill.nop", 4'd0, 5'b11000, S_FETCH);
`endif

      // reset mid-store aborts the pending write
      op = 7'b0100011;
      tick(); tick(); tick();
      mem_rdy = 1'b0; #1;
      look("ab.pre", 4'd5, 5'b00010, S_MEMRW);
      rst_n = 1'b0; mem_rdy = 1'b1; #1;
      look("ab.rst", 4'd0, 5'b00000, S_FETCH);
      tick();
      look("ab.hold", 4'd0, 5'b00000, S_FETCH);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Main control FSM for the multi-cycle RV32I core. It sequences the shared ALU, register file, instruction register and unified memory port one step per clock.
- Emits the 2-bit ALU operation class consumed by the ALU decoder: 00 = add, 01 = branch compare, 10 = funct-decoded.
- Also emits the datapath mux selects and write strobes.
- Sits between the instruction register opcode field and the datapath; memory accesses use a ready handshake.

Parameters:
- RESET_STATE, 4'd0, state entered on reset (FETCH); must be a legal state encoding.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- op  in  7  instruction opcode, IR[6:0], valid from DECODE onward
- cond  in  1  ALU branch-compare result (1 = taken), valid in BRANCH
- mem_rdy  in  1  memory port completes the current access this cycle
- alu_op  out  2  ALU operation class to the ALU decoder
- alu_src_a  out  2  ALU A select: 00 PC, 01 OldPC, 10 rs1 register
- alu_src_b  out  2  ALU B select: 00 rs2 register, 01 immediate, 10 constant 4
- result_src  out  2  result select: 00 ALUOut, 01 read data, 10 ALU result
- adr_src  out  1  memory address select: 0 PC, 1 result
- ir_write  out  1  load IR and OldPC
- pc_write  out  1  load PC from result
- reg_write  out  1  register file write
- mem_write  out  1  memory write request
- instr_done  out  1  one-cycle pulse on instruction retire
- state  out  4  current state, for debug

Behaviour:
- Moore FSM; all outputs decode from the current state, plus cond/mem_rdy where noted. State register is reset asynchronously to FETCH.
- While rst_n = 0: ir_write, pc_write, reg_write, mem_write and instr_done are forced to 0. Selects take their FETCH values. illegal (when present) = 0.
- Unlisted outputs are 0 in every state.
- Encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, JALR 11, TRAP 15. Codes 12–14 go to FETCH on the next clock.
- FETCH: adr_src 0, src_a 00, src_b 10, alu_op 00, result_src 10.
  - ir_write = pc_write = mem_rdy.
  - Stay while !mem_rdy; on mem_rdy go to DECODE. Single-cycle fetch when mem_rdy is already high.
- DECODE: src_a 01, src_b 01, alu_op 00 (branch/jal target into ALUOut). Next state by op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - anything else → illegal handling (see Optional Feature)
- MEMADR: src_a 10, src_b 01, alu_op 00. If op[5] = 0 → MEMREAD, else → MEMWRITE.
- MEMREAD: adr_src 1, result_src 00. Wait for mem_rdy, then → MEMWB.
- MEMWB: result_src 01, reg_write 1, instr_done 1 → FETCH.
- MEMWRITE: adr_src 1, result_src 00. mem_write is held at 1 until mem_rdy; instr_done = mem_rdy. On mem_rdy → FETCH.
- EXECR: src_a 10, src_b 00, alu_op 10 → ALUWB.
- EXECI: src_a 10, src_b 01, alu_op 10 → ALUWB.
- ALUWB: result_src 00, reg_write 1, instr_done 1 → FETCH.
- BRANCH: src_a 10, src_b 00, alu_op 01, result_src 00, pc_write = cond, instr_done 1 → FETCH.
- JALR: src_a 10, src_b 01, alu_op 00 (rs1 + imm into ALUOut) → JAL.
- JAL: src_a 01, src_b 10, alu_op 00, result_src 00, pc_write 1 (PC ← ALUOut) → ALUWB, which writes rd = OldPC + 4.
- alu_op 11 is never emitted.
- Latencies with mem_rdy always high:
  - R/I-type: 4 cycles
  - branch: 3 cycles
  - load: 5 cycles
  - store: 4 cycles
  - jal: 4 cycles
  - jalr: 5 cycles
- mem_rdy is ignored outside FETCH, MEMREAD and MEMWRITE.
- Reset asserted mid-instruction aborts it immediately: no partial strobe, restart at FETCH.

Optional Feature:
- Macro: MC_CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - Adds output port illegal (1 bit).
  - An unknown opcode in DECODE → TRAP. TRAP is absorbing until reset: all strobes 0, illegal = 1.
- Undefined:
  - No illegal port.
  - An unknown opcode in DECODE → FETCH with no writes and no instr_done; the instruction acts as a NOP.

Test Plan:
- Reset then release, mem_rdy = 1 → state sequence 0,1 with ir_write = pc_write = 1 in the first cycle; all strobes 0 while rst_n = 0.
- op = 0110011 (add) → states 0,1,6,8; alu_op 10 in EXECR; reg_write and instr_done pulse once in ALUWB.
- op = 0000011, mem_rdy low for 3 cycles in MEMREAD → state held at 3 for 3 cycles, then 4 with result_src 01 and reg_write 1.
- op = 1100011 with cond = 0, then cond = 1 → alu_op 01; pc_write 0 then 1 in BRANCH; 3 cycles each.
- op = 1100111 → states 1,11,10,8; pc_write in JAL; reg_write in ALUWB.
- op = 1111111 → with macro: state 15, illegal = 1 held until rst_n low. Without macro: return to FETCH, no strobes, no instr_done.
